// File: rtl/mc_sequencer_if.sv
// Control and handshake bundle between mc_sequencer and the RV64 datapath/memories.
// The master side is the sequencer; the slave side is the datapath plus memories.
interface mc_sequencer_if;
   // Datapath and memory status into the sequencer
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       et;
   logic       imem_ready;
   logic       dmem_ready;
   logic       step_mode;
   logic       step;
   // Control strobes out of the sequencer
   logic       imem_req;
   logic       dmem_req;
   logic       dmem_we;
   logic       load_ir;
   logic       pc_write;
   logic       reg_write;
   logic       load_a;
   logic       load_b;
   logic       load_aluout;
   logic       load_mdr;
   logic [2:0] alu_src_a;
   logic [2:0] alu_src_b;
   logic [2:0] alu_fct;
   logic [2:0] mem_to_reg;
   logic [2:0] instr_type;
   logic       retire;
   logic       fault;
   logic [1:0] fault_cause;

   modport master (
      input  opcode, funct3, funct7b5, et, imem_ready, dmem_ready, step_mode, step,
      output imem_req, dmem_req, dmem_we, load_ir, pc_write, reg_write, load_a, load_b,
             load_aluout, load_mdr, alu_src_a, alu_src_b, alu_fct, mem_to_reg,
             instr_type, retire, fault, fault_cause
   );

   modport slave (
      output opcode, funct3, funct7b5, et, imem_ready, dmem_ready, step_mode, step,
      input  imem_req, dmem_req, dmem_we, load_ir, pc_write, reg_write, load_a, load_b,
             load_aluout, load_mdr, alu_src_a, alu_src_b, alu_fct, mem_to_reg,
             instr_type, retire, fault, fault_cause
   );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer for the RV64 datapath: ready-based memory
// handshakes with timeout, single-step debug, illegal-opcode fault and a
// one-cycle retire pulse. Strobes are registered (computed for the state
// being entered); only load_ir/load_mdr follow the ready inputs directly.
module mc_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TMO_W       = 8
) (
   input  logic           clock_i,
   input  logic           reset_ni,
   mc_sequencer_if.master seq_if
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCADV, S_BRANCH, S_FAULT
   } state_e;

   typedef enum logic [3:0] {
      C_R, C_IALU, C_LD, C_SD, C_BEQ, C_BNE, C_JAL, C_LUI, C_ILL
   } cls_e;

   typedef struct packed {
      logic       imem_req;
      logic       dmem_req;
      logic       dmem_we;
      logic       pc_write;
      logic       reg_write;
      logic       load_a;
      logic       load_b;
      logic       load_aluout;
      logic [2:0] alu_src_a;
      logic [2:0] alu_src_b;
      logic [2:0] alu_fct;
      logic [2:0] mem_to_reg;
      logic       retire;
   } ctrl_t;

   localparam logic [2:0] SRC_A_PC   = 3'd0;
   localparam logic [2:0] SRC_A_REG  = 3'd1;
   localparam logic [2:0] SRC_A_ZERO = 3'd2;
   localparam logic [2:0] SRC_B_REG  = 3'd0;
   localparam logic [2:0] SRC_B_FOUR = 3'd1;
   localparam logic [2:0] SRC_B_IMM  = 3'd2;
   localparam logic [2:0] FCT_ADD    = 3'd1;
   localparam logic [2:0] FCT_SUB    = 3'd2;
   localparam logic [2:0] FCT_AND    = 3'd3;
   localparam logic [2:0] FCT_XOR    = 3'd6;
   localparam logic [2:0] WB_MDR     = 3'd0;
   localparam logic [2:0] WB_ALUOUT  = 3'd1;
   localparam logic [2:0] IT_R       = 3'd0;
   localparam logic [2:0] IT_I       = 3'd1;
   localparam logic [2:0] IT_S       = 3'd2;
   localparam logic [2:0] IT_SB      = 3'd3;
   localparam logic [2:0] IT_U       = 3'd4;
   localparam logic [2:0] IT_UJ      = 3'd5;
   localparam logic [1:0] CAUSE_ILL  = 2'd1;
   localparam logic [1:0] CAUSE_IMEM = 2'd2;
   localparam logic [1:0] CAUSE_DMEM = 2'd3;

   // A zero timeout means "wait forever"
   localparam bit               TMO_EN  = (MEM_TIMEOUT != 0);
   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

   state_e           state_q;
   ctrl_t            ctrl_q;
   cls_e             cls_q;
   logic [2:0]       fct_q;
   logic [2:0]       itype_q;
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             fault_q;
   logic [1:0]       cause_q;

   cls_e             dec_cls;
   logic [2:0]       dec_fct;
   logic [2:0]       dec_itype;
   logic             br_taken;
   logic             in_flight;

   // Strobe set for a given state; the FSM registers it on entry to that state
   function automatic ctrl_t ctrl_for(input state_e s, input cls_e c,
                                      input logic [2:0] fct, input logic taken);
      ctrl_t k;
      k = '0;
      case (s)
         S_FETCH:  k.imem_req = 1'b1;
         S_DECODE: begin
            k.load_a = 1'b1;
            k.load_b = 1'b1;
         end
         S_EXEC: begin
            case (c)
               C_R: begin
                  k.alu_src_a = SRC_A_REG;  k.alu_src_b = SRC_B_REG;
                  k.alu_fct   = fct;        k.load_aluout = 1'b1;
               end
               C_IALU: begin
                  k.alu_src_a = SRC_A_REG;  k.alu_src_b = SRC_B_IMM;
                  k.alu_fct   = fct;        k.load_aluout = 1'b1;
               end
               C_LD, C_SD: begin
                  k.alu_src_a = SRC_A_REG;  k.alu_src_b = SRC_B_IMM;
                  k.alu_fct   = FCT_ADD;    k.load_aluout = 1'b1;
               end
               C_LUI: begin
                  k.alu_src_a = SRC_A_ZERO; k.alu_src_b = SRC_B_IMM;
                  k.alu_fct   = FCT_ADD;    k.load_aluout = 1'b1;
               end
               C_JAL: begin
                  k.alu_src_a = SRC_A_PC;   k.alu_src_b = SRC_B_FOUR;
                  k.alu_fct   = FCT_ADD;    k.load_aluout = 1'b1;
               end
               C_BEQ, C_BNE: begin
                  // Compare only: the equality flag is consumed, ALUout is kept
                  k.alu_src_a = SRC_A_REG;  k.alu_src_b = SRC_B_REG;
                  k.alu_fct   = FCT_SUB;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            k.dmem_req = 1'b1;
            k.dmem_we  = (c == C_SD);
         end
         S_WB: begin
            k.reg_write  = 1'b1;
            k.mem_to_reg = (c == C_LD) ? WB_MDR : WB_ALUOUT;
            k.pc_write   = 1'b1;
            k.alu_src_a  = SRC_A_PC;
            k.alu_src_b  = (c == C_JAL) ? SRC_B_IMM : SRC_B_FOUR;
            k.alu_fct    = FCT_ADD;
            k.retire     = 1'b1;
         end
         S_PCADV: begin
            k.pc_write  = 1'b1;
            k.alu_src_a = SRC_A_PC;
            k.alu_src_b = SRC_B_FOUR;
            k.alu_fct   = FCT_ADD;
            k.retire    = 1'b1;
         end
         S_BRANCH: begin
            k.pc_write  = 1'b1;
            k.alu_src_a = SRC_A_PC;
            k.alu_src_b = taken ? SRC_B_IMM : SRC_B_FOUR;
            k.alu_fct   = FCT_ADD;
            k.retire    = 1'b1;
         end
         default: ;
      endcase
      return k;
   endfunction

   // Instruction decode from the IR fields: class, ALU function and format
   always_comb begin
      dec_cls   = C_ILL;
      dec_fct   = FCT_ADD;
      dec_itype = IT_R;
      case (seq_if.opcode)
         7'b0110011: begin
            dec_itype = IT_R;
            case ({seq_if.funct3, seq_if.funct7b5})
               4'b000_0: begin dec_cls = C_R; dec_fct = FCT_ADD; end
               4'b000_1: begin dec_cls = C_R; dec_fct = FCT_SUB; end
               4'b111_0: begin dec_cls = C_R; dec_fct = FCT_AND; end
               4'b100_0: begin dec_cls = C_R; dec_fct = FCT_XOR; end
               default:  dec_cls = C_ILL;
            endcase
         end
         7'b0010011: begin
            dec_itype = IT_I;
            case (seq_if.funct3)
               3'b000:  begin dec_cls = C_IALU; dec_fct = FCT_ADD; end
               3'b111:  begin dec_cls = C_IALU; dec_fct = FCT_AND; end
               3'b100:  begin dec_cls = C_IALU; dec_fct = FCT_XOR; end
               default: dec_cls = C_ILL;
            endcase
         end
         7'b0000011: begin
            dec_itype = IT_I;
            if (seq_if.funct3 == 3'b011) dec_cls = C_LD;
         end
         7'b0100011: begin
            dec_itype = IT_S;
            if (seq_if.funct3 == 3'b011) dec_cls = C_SD;
         end
         7'b1100011: begin
            dec_itype = IT_SB;
            if (seq_if.funct3 == 3'b000)      dec_cls = C_BEQ;
            else if (seq_if.funct3 == 3'b001) dec_cls = C_BNE;
         end
         7'b1101111: begin dec_itype = IT_UJ; dec_cls = C_JAL; end
         7'b0110111: begin dec_itype = IT_U;  dec_cls = C_LUI; end
         default: ;
      endcase
   end

   assign br_taken  = ((cls_q == C_BEQ) && seq_if.et) || ((cls_q == C_BNE) && !seq_if.et);
   assign in_flight = state_q inside {S_EXEC, S_MEM, S_WB, S_PCADV, S_BRANCH};

   // Sequencer FSM: next state, registered strobes, wait counter and sticky fault
   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         state_q   <= S_IDLE;
         ctrl_q    <= '0;
         cls_q     <= C_ILL;
         fct_q     <= '0;
         itype_q   <= '0;
         tmo_cnt_q <= '0;
         fault_q   <= 1'b0;
         cause_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!seq_if.step_mode || seq_if.step) begin
                  state_q   <= S_FETCH;
                  ctrl_q    <= ctrl_for(S_FETCH, cls_q, fct_q, 1'b0);
                  tmo_cnt_q <= '0;
               end
            end
            S_FETCH: begin
               if (seq_if.imem_ready) begin
                  state_q <= S_DECODE;
                  ctrl_q  <= ctrl_for(S_DECODE, cls_q, fct_q, 1'b0);
               end else if (TMO_EN && (tmo_cnt_q == TMO_LIM)) begin
                  state_q <= S_FAULT;
                  ctrl_q  <= '0;
                  fault_q <= 1'b1;
                  cause_q <= CAUSE_IMEM;
               end else if (tmo_cnt_q != '1) begin
                  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
               end
            end
            S_DECODE: begin
               cls_q   <= dec_cls;
               fct_q   <= dec_fct;
               itype_q <= dec_itype;
               if (dec_cls == C_ILL) begin
                  state_q <= S_FAULT;
                  ctrl_q  <= '0;
                  fault_q <= 1'b1;
                  cause_q <= CAUSE_ILL;
               end else begin
                  state_q <= S_EXEC;
                  ctrl_q  <= ctrl_for(S_EXEC, dec_cls, dec_fct, 1'b0);
               end
            end
            S_EXEC: begin
               case (cls_q)
                  C_LD, C_SD: begin
                     state_q   <= S_MEM;
                     ctrl_q    <= ctrl_for(S_MEM, cls_q, fct_q, 1'b0);
                     tmo_cnt_q <= '0;
                  end
                  C_BEQ, C_BNE: begin
                     // et is valid now, while the ALU compares A and B
                     state_q <= S_BRANCH;
                     ctrl_q  <= ctrl_for(S_BRANCH, cls_q, fct_q, br_taken);
                  end
                  default: begin
                     state_q <= S_WB;
                     ctrl_q  <= ctrl_for(S_WB, cls_q, fct_q, 1'b0);
                  end
               endcase
            end
            S_MEM: begin
               if (seq_if.dmem_ready) begin
                  if (cls_q == C_LD) begin
                     state_q <= S_WB;
                     ctrl_q  <= ctrl_for(S_WB, cls_q, fct_q, 1'b0);
                  end else begin
                     state_q <= S_PCADV;
                     ctrl_q  <= ctrl_for(S_PCADV, cls_q, fct_q, 1'b0);
                  end
               end else if (TMO_EN && (tmo_cnt_q == TMO_LIM)) begin
                  state_q <= S_FAULT;
                  ctrl_q  <= '0;
                  fault_q <= 1'b1;
                  cause_q <= CAUSE_DMEM;
               end else if (tmo_cnt_q != '1) begin
                  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
               end
            end
            S_WB, S_PCADV, S_BRANCH: begin
               state_q <= S_IDLE;
               ctrl_q  <= '0;
            end
            S_FAULT: ;
            default: begin
               state_q <= S_IDLE;
               ctrl_q  <= '0;
            end
         endcase
      end
   end

   assign seq_if.imem_req    = ctrl_q.imem_req;
   assign seq_if.dmem_req    = ctrl_q.dmem_req;
   assign seq_if.dmem_we     = ctrl_q.dmem_we;
   assign seq_if.pc_write    = ctrl_q.pc_write;
   assign seq_if.reg_write   = ctrl_q.reg_write;
   assign seq_if.load_a      = ctrl_q.load_a;
   assign seq_if.load_b      = ctrl_q.load_b;
   assign seq_if.load_aluout = ctrl_q.load_aluout;
   assign seq_if.alu_src_a   = ctrl_q.alu_src_a;
   assign seq_if.alu_src_b   = ctrl_q.alu_src_b;
   assign seq_if.alu_fct     = ctrl_q.alu_fct;
   assign seq_if.mem_to_reg  = ctrl_q.mem_to_reg;
   assign seq_if.retire      = ctrl_q.retire;
   assign seq_if.fault       = fault_q;
   assign seq_if.fault_cause = cause_q;

   // Ready-qualified loads capture the word in the same cycle it is valid
   assign seq_if.load_ir  = (state_q == S_FETCH) && seq_if.imem_ready;
   assign seq_if.load_mdr = (state_q == S_MEM) && seq_if.dmem_ready && (cls_q == C_LD);

   // Format straight from the IR in DECODE, then held for the rest of the instruction
   assign seq_if.instr_type = (state_q == S_DECODE) ? dec_itype :
                              in_flight             ? itype_q   : IT_R;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed test-plan steps followed by
// random instructions, each expanded into an expected per-cycle trace.
module tb_mc_sequencer;
   localparam int T = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mc_sequencer_if sif();

   mc_sequencer #(.MEM_TIMEOUT(T), .TMO_W(8)) dut (
      .clock_i (clk),
      .reset_ni(rst_n),
      .seq_if  (sif)
   );

   typedef enum int {K_ADD, K_SUB, K_AND, K_XOR, K_ADDI, K_ANDI, K_XORI,
                     K_LD, K_SD, K_BEQ, K_BNE, K_JAL, K_LUI, K_ILL} kind_e;

   typedef struct {
      logic [6:0] opc;
      logic [2:0] f3;
      logic       f7;
      bit         use_f3;
      bit         use_f7;
      kind_e      k;
   } enc_t;

   typedef struct packed {
      logic       imem_req, dmem_req, dmem_we, load_ir, pc_write, reg_write;
      logic       load_a, load_b, load_aluout, load_mdr;
      logic [2:0] src_a, src_b, fct, m2r;
      logic       retire, fault;
      logic [1:0] cause;
   } out_t;

   typedef struct {
      logic       rst_n, imr, dmr, smode, stp, et, f7;
      logic [6:0] opc;
      logic [2:0] f3;
      out_t       exp;
      bit         chk_it;
      logic [2:0] exp_it;
      string      tag;
   } cyc_t;

   enc_t  tbl[$];
   cyc_t  q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    instr_no = 0;

   function automatic void add_enc(input logic [6:0] o, input logic [2:0] f, input logic b,
                                   input bit uf3, input bit uf7, input kind_e k);
      enc_t e;
      e.opc = o; e.f3 = f; e.f7 = b; e.use_f3 = uf3; e.use_f7 = uf7; e.k = k;
      tbl.push_back(e);
   endfunction

   // Legal encodings; anything that matches no row is illegal
   function automatic kind_e kind_of(input logic [6:0] o, input logic [2:0] f, input logic b);
      foreach (tbl[i])
         if (o == tbl[i].opc && (!tbl[i].use_f3 || f == tbl[i].f3) &&
             (!tbl[i].use_f7 || b == tbl[i].f7))
            return tbl[i].k;
      return K_ILL;
   endfunction

   function automatic logic [2:0] fct_of(input kind_e k);
      case (k)
         K_SUB, K_BEQ, K_BNE: return 3'd2;
         K_AND, K_ANDI:       return 3'd3;
         K_XOR, K_XORI:       return 3'd6;
         default:             return 3'd1;
      endcase
   endfunction

   function automatic logic [2:0] itype_of(input kind_e k);
      case (k)
         K_ADD, K_SUB, K_AND, K_XOR: return 3'd0;
         K_SD:                       return 3'd2;
         K_BEQ, K_BNE:               return 3'd3;
         K_LUI:                      return 3'd4;
         K_JAL:                      return 3'd5;
         default:                    return 3'd1;
      endcase
   endfunction

   // A cycle with random don't-care inputs and an all-zero expectation
   function automatic cyc_t bg(input string tag);
      cyc_t c;
      c.rst_n = 1'b1;          c.imr = 1'($urandom);  c.dmr = 1'($urandom);
      c.smode = 1'($urandom);  c.stp = 1'($urandom);  c.et = 1'($urandom);
      c.opc = 7'($urandom);    c.f3 = 3'($urandom);   c.f7 = 1'($urandom);
      c.exp = '0; c.chk_it = 1'b0; c.exp_it = 3'd0;
      c.tag = $sformatf("#%0d %s", instr_no, tag);
      return c;
   endfunction

   function automatic void fault_seq(input logic [1:0] cause);
      cyc_t c;
      for (int i = 0; i < 20; i++) begin
         c = bg("FAULT-hold");
         c.exp.fault = 1'b1; c.exp.cause = cause;
         q.push_back(c);
      end
      c = bg("FAULT-reset");
      c.rst_n = 1'b0; c.exp.fault = 1'b1; c.exp.cause = cause;
      q.push_back(c);
   endfunction

   // Expand one instruction into its expected cycle trace.
   // abort: 1 = reset during the first fetch wait, 2 = reset during the first data wait.
   function automatic void gen_instr(input logic [6:0] o, input logic [2:0] f, input logic b,
                                     input int si, input int sd, input logic et,
                                     input bit smode, input int iwait, input int abort);
      kind_e k = kind_of(o, f, b);
      cyc_t  c;
      bit    taken;
      instr_no++;
      if (smode) begin
         for (int w = 0; w < iwait; w++) begin
            c = bg("IDLE-wait"); c.smode = 1'b1; c.stp = 1'b0; q.push_back(c);
         end
         c = bg("IDLE-step"); c.smode = 1'b1; c.stp = 1'b1; q.push_back(c);
      end else begin
         c = bg("IDLE"); c.smode = 1'b0; q.push_back(c);
      end
      if (abort == 1) begin
         c = bg("FETCH-rst"); c.imr = 1'b0; c.rst_n = 1'b0; c.exp.imem_req = 1'b1;
         q.push_back(c);
         return;
      end
      for (int i = 0; i < si && i <= T; i++) begin
         c = bg("FETCH-wait"); c.imr = 1'b0; c.exp.imem_req = 1'b1; q.push_back(c);
      end
      if (si > T) begin fault_seq(2'd2); return; end
      c = bg("FETCH"); c.imr = 1'b1; c.exp.imem_req = 1'b1; c.exp.load_ir = 1'b1;
      q.push_back(c);
      // From DECODE on the IR holds this instruction and et is its compare result
      c = bg("DECODE"); c.opc = o; c.f3 = f; c.f7 = b; c.et = et;
      c.exp.load_a = 1'b1; c.exp.load_b = 1'b1;
      if (k != K_ILL) begin c.chk_it = 1'b1; c.exp_it = itype_of(k); end
      q.push_back(c);
      if (k == K_ILL) begin fault_seq(2'd1); return; end
      c = bg("EXEC"); c.opc = o; c.f3 = f; c.f7 = b; c.et = et;
      case (k)
         K_ADD, K_SUB, K_AND, K_XOR: begin
            c.exp.src_a = 3'd1; c.exp.src_b = 3'd0; c.exp.fct = fct_of(k); c.exp.load_aluout = 1'b1;
         end
         K_BEQ, K_BNE: begin
            c.exp.src_a = 3'd1; c.exp.src_b = 3'd0; c.exp.fct = 3'd2;
         end
         K_LUI: begin
            c.exp.src_a = 3'd2; c.exp.src_b = 3'd2; c.exp.fct = 3'd1; c.exp.load_aluout = 1'b1;
         end
         K_JAL: begin
            c.exp.src_a = 3'd0; c.exp.src_b = 3'd1; c.exp.fct = 3'd1; c.exp.load_aluout = 1'b1;
         end
         default: begin
            c.exp.src_a = 3'd1; c.exp.src_b = 3'd2; c.exp.fct = fct_of(k); c.exp.load_aluout = 1'b1;
         end
      endcase
      q.push_back(c);
      if (k == K_LD || k == K_SD) begin
         if (abort == 2) begin
            c = bg("MEM-rst"); c.opc = o; c.f3 = f; c.f7 = b; c.et = et;
            c.dmr = 1'b0; c.rst_n = 1'b0; c.exp.dmem_req = 1'b1; c.exp.dmem_we = (k == K_SD);
            q.push_back(c);
            return;
         end
         for (int i = 0; i < sd && i <= T; i++) begin
            c = bg("MEM-wait"); c.opc = o; c.f3 = f; c.f7 = b; c.et = et;
            c.dmr = 1'b0; c.exp.dmem_req = 1'b1; c.exp.dmem_we = (k == K_SD);
            q.push_back(c);
         end
         if (sd > T) begin fault_seq(2'd3); return; end
         c = bg("MEM"); c.opc = o; c.f3 = f; c.f7 = b; c.et = et;
         c.dmr = 1'b1; c.exp.dmem_req = 1'b1; c.exp.dmem_we = (k == K_SD);
         c.exp.load_mdr = (k == K_LD);
         q.push_back(c);
      end
      c = bg("RETIRE"); c.opc = o; c.f3 = f; c.f7 = b; c.et = et;
      c.exp.pc_write = 1'b1; c.exp.retire = 1'b1; c.exp.src_a = 3'd0; c.exp.fct = 3'd1;
      if (k == K_BEQ || k == K_BNE) begin
         taken = (k == K_BEQ) ? et : !et;
         c.exp.src_b = taken ? 3'd2 : 3'd1;
      end else if (k == K_SD) begin
         c.exp.src_b = 3'd1;
      end else begin
         c.exp.reg_write = 1'b1;
         c.exp.m2r = (k == K_LD) ? 3'd0 : 3'd1;
         c.exp.src_b = (k == K_JAL) ? 3'd2 : 3'd1;
      end
      q.push_back(c);
   endfunction

   // Drive each queued cycle after the edge and check the outputs mid-cycle
   task automatic play();
      cyc_t c;
      out_t got;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(posedge clk);
         #1;
         rst_n = c.rst_n;           sif.imem_ready = c.imr;  sif.dmem_ready = c.dmr;
         sif.step_mode = c.smode;   sif.step = c.stp;        sif.et = c.et;
         sif.opcode = c.opc;        sif.funct3 = c.f3;       sif.funct7b5 = c.f7;
         @(negedge clk);
         got.imem_req = sif.imem_req;   got.dmem_req = sif.dmem_req;   got.dmem_we = sif.dmem_we;
         got.load_ir = sif.load_ir;     got.pc_write = sif.pc_write;   got.reg_write = sif.reg_write;
         got.load_a = sif.load_a;       got.load_b = sif.load_b;       got.load_aluout = sif.load_aluout;
         got.load_mdr = sif.load_mdr;   got.src_a = sif.alu_src_a;     got.src_b = sif.alu_src_b;
         got.fct = sif.alu_fct;         got.m2r = sif.mem_to_reg;      got.retire = sif.retire;
         got.fault = sif.fault;         got.cause = sif.fault_cause;
         n_checks++;
         assert (got === c.exp) else begin
            n_fail++;
            $error("FAIL %s outputs: observed=%h expected=%h", c.tag, got, c.exp);
         end
         if (c.chk_it) begin
            n_checks++;
            assert (sif.instr_type === c.exp_it) else begin
               n_fail++;
               $error("FAIL %s instr_type: observed=%0d expected=%0d", c.tag, sif.instr_type, c.exp_it);
            end
         end
      end
   endtask

   function automatic int rnd_stall();
      int r = $urandom_range(0, 19);
      if (r == 0) return T + 1 + $urandom_range(0, 2);
      if (r < 12) return 0;
      return $urandom_range(1, T);
   endfunction

   task automatic run(input logic [6:0] o, input logic [2:0] f, input logic b,
                      input int si, input int sd, input logic et,
                      input bit smode, input int iwait, input int abort, input string name);
      gen_instr(o, f, b, si, sd, et, smode, iwait, abort);
      play();
      $display("instr %0d %s op=%b f3=%b f7=%b si=%0d sd=%0d et=%0d step=%0d abort=%0d checks=%0d",
               instr_no, name, o, f, b, si, sd, et, smode, abort, n_checks);
   endtask

   initial begin
      cyc_t c;
      logic [6:0] o;
      logic [2:0] f;
      logic       b;
      int         idx;
      sif.imem_ready = 1'b0; sif.dmem_ready = 1'b0; sif.step_mode = 1'b0; sif.step = 1'b0;
      sif.et = 1'b0; sif.opcode = '0; sif.funct3 = '0; sif.funct7b5 = 1'b0;

      add_enc(7'b0110011, 3'b000, 1'b0, 1, 1, K_ADD);
      add_enc(7'b0110011, 3'b000, 1'b1, 1, 1, K_SUB);
      add_enc(7'b0110011, 3'b111, 1'b0, 1, 1, K_AND);
      add_enc(7'b0110011, 3'b100, 1'b0, 1, 1, K_XOR);
      add_enc(7'b0010011, 3'b000, 1'b0, 1, 0, K_ADDI);
      add_enc(7'b0010011, 3'b111, 1'b0, 1, 0, K_ANDI);
      add_enc(7'b0010011, 3'b100, 1'b0, 1, 0, K_XORI);
      add_enc(7'b0000011, 3'b011, 1'b0, 1, 0, K_LD);
      add_enc(7'b0100011, 3'b011, 1'b0, 1, 0, K_SD);
      add_enc(7'b1100011, 3'b000, 1'b0, 1, 0, K_BEQ);
      add_enc(7'b1100011, 3'b001, 1'b0, 1, 0, K_BNE);
      add_enc(7'b1101111, 3'b000, 1'b0, 0, 0, K_JAL);
      add_enc(7'b0110111, 3'b000, 1'b0, 0, 0, K_LUI);

      // Reset state
      c = bg("RESET"); c.rst_n = 1'b0; q.push_back(c);
      play();

      // Directed steps from the test plan
      run(7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0, 0, 0, 0, "ADD");
      run(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b1, 0, 0, 0, "BNE et=1");
      run(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b0, 0, 0, 0, "BNE et=0");
      run(7'b0000011, 3'b011, 1'b0, 0, 3, 1'b0, 0, 0, 0, "LD dmem wait 3");
      run(7'b0110011, 3'b000, 1'b0, 1000, 0, 1'b0, 0, 0, 0, "imem stuck");
      run(7'b1110011, 3'b000, 1'b0, 0, 0, 1'b0, 0, 0, 0, "illegal 1110011");
      run(7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0, 1, 3, 0, "step ADDI");
      run(7'b0010011, 3'b000, 1'b0, 2, 0, 1'b1, 1, 1, 0, "step ADDI");
      run(7'b0100011, 3'b011, 1'b0, 1, 2, 1'b0, 0, 0, 0, "SD");
      run(7'b1101111, 3'b101, 1'b1, 0, 0, 1'b0, 0, 0, 0, "JAL");
      run(7'b0110111, 3'b010, 1'b0, 0, 0, 1'b1, 0, 0, 0, "LUI");
      run(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1, 0, 0, 0, "BEQ et=1");
      run(7'b0110011, 3'b000, 1'b1, T, 0, 1'b0, 0, 0, 0, "SUB fetch wait at limit");
      run(7'b0000011, 3'b011, 1'b0, 0, T + 1, 1'b0, 0, 0, 0, "LD dmem timeout");
      run(7'b0110011, 3'b111, 1'b0, 2, 0, 1'b0, 0, 0, 1, "reset mid fetch");
      run(7'b0000011, 3'b011, 1'b0, 0, 2, 1'b0, 0, 0, 2, "reset mid mem");
      run(7'b0110011, 3'b100, 1'b0, 0, 0, 1'b0, 0, 0, 0, "XOR after reset");

      // Random instructions, mostly legal encodings with random don't-care bits
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) < 8) begin
            idx = $urandom_range(0, tbl.size() - 1);
            o = tbl[idx].opc;
            f = tbl[idx].use_f3 ? tbl[idx].f3 : 3'($urandom);
            b = tbl[idx].use_f7 ? tbl[idx].f7 : 1'($urandom);
         end else begin
            o = 7'($urandom); f = 3'($urandom); b = 1'($urandom);
         end
         run(o, f, b, rnd_stall(), rnd_stall(), 1'($urandom),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
             ($urandom_range(0, 29) == 0) ? $urandom_range(1, 2) : 0, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Parametrised multicycle control sequencer for the RV64 datapath. It supersedes the fixed-latency control unit with:
- ready-based instruction and data memory handshakes, with a configurable timeout that raises a sticky fault;
- a single-step debug mode;
- illegal-opcode detection and a one-cycle retire pulse.

It drives the PC, IR, A/B, ALUout and MDR load enables, the three datapath mux selects, the ALU function select and the memory strobes.

## Interface
Parameters:
- MEM_TIMEOUT, 15: cycles a memory request may wait for ready before fault; 0 disables the timeout.
- TMO_W, 8: width of the wait counter; MEM_TIMEOUT must be < 2**TMO_W.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- et  in  1  ALU equality flag
- imem_ready  in  1  instruction word valid
- dmem_ready  in  1  data access complete
- step_mode  in  1  single-step enable
- step  in  1  one-cycle step pulse
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data request
- dmem_we  out  1  store qualifier
- load_ir  out  1  IR load enable
- pc_write  out  1  PC load enable
- reg_write  out  1  register bank write enable
- load_a  out  1  register A load enable
- load_b  out  1  register B load enable
- load_aluout  out  1  ALUout load enable
- load_mdr  out  1  MDR load enable
- alu_src_a  out  3  0=PC, 1=A, 2=zero
- alu_src_b  out  3  0=B, 1=4, 2=imm
- alu_fct  out  3  0=idle, 1=ADD, 2=SUB, 3=AND, 6=XOR
- mem_to_reg  out  3  0=MDR, 1=ALUout
- instr_type  out  3  0=R, 1=I, 2=S, 3=SB, 4=U, 5=UJ
- retire  out  1  pulse on the instruction-completing cycle
- fault  out  1  sticky: illegal opcode or timeout
- fault_cause  out  2  0=none, 1=illegal, 2=imem timeout, 3=dmem timeout

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCADV, BRANCH, FAULT.
- IDLE:
  - step_mode=0 → FETCH next cycle.
  - step_mode=1 → wait for step=1, then FETCH.
- FETCH:
  - imem_req=1 held while imem_ready=0.
  - On ready: load_ir=1 → DECODE.
- DECODE, one cycle:
  - load_a=1, load_b=1; instr_type from opcode.
  - Illegal opcode/funct → FAULT, cause 1.
- EXEC:
  - R: ALUout←A op B (src_a=1, src_b=0).
  - I-ALU: ALUout←A op imm.
  - LD/SD: ALUout←A+imm.
  - LUI: ALUout←zero+imm.
  - JAL: ALUout←PC+4.
  - BEQ/BNE: ALU SUB A,B; no load_aluout; → BRANCH.
- MEM:
  - dmem_req=1 (dmem_we=1 for SD) held until dmem_ready.
  - LD: load_mdr=1 on ready → WB.
  - SD: on ready → PCADV.
- WB:
  - reg_write=1 (mem_to_reg=0 for LD, else 1).
  - Same cycle, pc_write=1 with:
    - PC+imm (src_a=0, src_b=2, ADD) for JAL;
    - PC+4 otherwise.
  - retire=1 → IDLE.
- PCADV: pc_write=1 with PC+4; retire=1 → IDLE.
- BRANCH:
  - Taken iff (BEQ and et) or (BNE and !et).
  - pc_write=1 with PC+imm if taken, else PC+4; retire=1 → IDLE.
- Legal decode:
  - R 0110011, funct3/funct7b5: 000/0 ADD, 000/1 SUB, 111/0 AND, 100/0 XOR.
  - I-ALU 0010011: funct3 000/111/100.
  - LOAD 0000011 funct3 011; STORE 0100011 funct3 011.
  - BRANCH 1100011 funct3 000/001; JAL 1101111; LUI 0110111.
  - Anything else is illegal.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle ready=0.
  - When counter == MEM_TIMEOUT with ready still 0 → FAULT, cause 2 (FETCH) or 3 (MEM).
- FAULT: all strobes 0, fault=1, held until reset.

## Timing
- Reset (reset=0 at an edge): state IDLE, counter 0, every output 0 next cycle. Reset mid-request drops imem_req/dmem_req in the following cycle.
- Minimum cycles with ready already high in FETCH/MEM:
  - R/I/LUI/JAL/BEQ/BNE: 5 (IDLE, FETCH, DECODE, EXEC, WB-or-BRANCH).
  - LD, SD: 6.
- Each extra cycle of ready=0 adds one cycle.
- Ready sampled in the same cycle the request is asserted counts; zero-wait is allowed.
- step pulses arriving outside IDLE are ignored; step_mode is sampled only in IDLE.
- retire is exactly one cycle per instruction, coincident with pc_write.
- Outputs are Moore except the ready-qualified strobes: load_ir, load_mdr, and the ready-gated FETCH/MEM exits.

## Test plan
- ADD, imem_ready tied high: states IDLE, FETCH, DECODE, EXEC, WB. reg_write, pc_write and retire all 1 in cycle 5; alu_fct=1.
- BNE with et=1, then et=0: first gives pc_write with src_b=1 (PC+4); second gives src_b=2 (PC+imm). Both in BRANCH, retire=1.
- LD with dmem_ready low 3 cycles: dmem_req high 4 cycles, load_mdr=1 in the 4th. WB follows with mem_to_reg=0; total 9 cycles.
- MEM_TIMEOUT=4, imem_ready stuck 0: imem_req drops after the timeout expires; fault=1, fault_cause=2; stays stuck through 20 further cycles.
- Opcode 1110011 in DECODE → FAULT next cycle, fault_cause=1; reset=0 for one cycle clears fault and returns to IDLE.
- step_mode=1: no imem_req until step; each step pulse retires exactly one ADDI. A step during EXEC is ignored.
